// File: rtl/t_pulse_gen.sv
// t_pulse_gen: synchronizes and debounces a raw push-button level and emits a
// single-cycle toggle pulse (t) for each accepted press. Releases update the
// debounced level only. Accepted presses are counted modulo 2^CNT_W.
module t_pulse_gen #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    output logic             t,
    output logic             btn_db,
    output logic             busy,
    output logic [CNT_W-1:0] press_cnt
);

    // Stability counter only ever needs to reach STABLE_CYCLES-1.
    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    logic              sync1_r;
    logic              sync2_r;
    logic              sample_s;
    state_t            state_r;
    state_t            state_s;
    logic [STAB_W-1:0] cnt_r;
    logic [STAB_W-1:0] cnt_s;
    logic              rise_ok_s;
    logic              fall_ok_s;
    logic              busy_s;
    logic              t_r;
    logic              btn_db_r;
    logic [CNT_W-1:0]  press_cnt_r;

    // Two-flop synchronizer; the only reader of the asynchronous btn_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
        end
    end

    assign sample_s = sync2_r;

    // State and stability-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE_LO;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; the counter defaults to 0 so it is clean on every
    // entry into a WAIT state and after any aborted qualification.
    always_comb begin
        state_s   = state_r;
        cnt_s     = '0;
        rise_ok_s = 1'b0;
        fall_ok_s = 1'b0;
        case (state_r)
            IDLE_LO: begin
                if (sample_s) begin
                    state_s = WAIT_HI;
                end else begin
                    state_s = IDLE_LO;
                end
            end
            WAIT_HI: begin
                if (!sample_s) begin
                    state_s = IDLE_LO;
                end else if (cnt_r == STAB_LAST) begin
                    state_s   = IDLE_HI;
                    rise_ok_s = 1'b1;
                end else begin
                    state_s = WAIT_HI;
                    cnt_s   = cnt_r + STAB_W'(1);
                end
            end
            IDLE_HI: begin
                if (!sample_s) begin
                    state_s = WAIT_LO;
                end else begin
                    state_s = IDLE_HI;
                end
            end
            WAIT_LO: begin
                if (sample_s) begin
                    state_s = IDLE_HI;
                end else if (cnt_r == STAB_LAST) begin
                    state_s   = IDLE_LO;
                    fall_ok_s = 1'b1;
                end else begin
                    state_s = WAIT_LO;
                    cnt_s   = cnt_r + STAB_W'(1);
                end
            end
            default: begin
                state_s = IDLE_LO;
            end
        endcase
    end

    // Busy decode straight from the state register.
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            WAIT_HI: busy_s = 1'b1;
            WAIT_LO: busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Registered pulse, debounced level and press counter; only a qualified
    // rise produces t, so a held button yields a single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_r         <= 1'b0;
            btn_db_r    <= 1'b0;
            press_cnt_r <= '0;
        end else begin
            t_r <= rise_ok_s;
            if (rise_ok_s) begin
                btn_db_r    <= 1'b1;
                press_cnt_r <= press_cnt_r + CNT_W'(1);
            end else if (fall_ok_s) begin
                btn_db_r    <= 1'b0;
                press_cnt_r <= press_cnt_r;
            end else begin
                btn_db_r    <= btn_db_r;
                press_cnt_r <= press_cnt_r;
            end
        end
    end

    assign t         = t_r;
    assign btn_db    = btn_db_r;
    assign busy      = busy_s;
    assign press_cnt = press_cnt_r;

endmodule
